// File: rtl/spi_pkg.sv
// Shared constants for the SPI slave: mode encodings, FSM state codes and
// helpers that split a mode into its clock polarity and phase.
package spi_pkg;

  localparam logic [1:0] MODE_CPOL0_CPHA0 = 2'b00;
  localparam logic [1:0] MODE_CPOL0_CPHA1 = 2'b01;
  localparam logic [1:0] MODE_CPOL1_CPHA1 = 2'b10;
  localparam logic [1:0] MODE_CPOL1_CPHA0 = 2'b11;

  localparam logic STATE_IDLE   = 1'b0;
  localparam logic STATE_ACTIVE = 1'b1;

  function automatic logic mode_cpol(input logic [1:0] mode);
    return mode[1];
  endfunction

  // Modes 01 and 10 are the phase-1 encodings.
  function automatic logic mode_cpha(input logic [1:0] mode);
    return mode[1] ^ mode[0];
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Two-flop synchronizer for one asynchronous SPI pin, followed by a history
// flop so rising and falling edges of the synchronized level can be detected.
module spi_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic hist;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= RESET_VAL;
      sync <= RESET_VAL;
      hist <= RESET_VAL;
    end else begin
      meta <= d;
      sync <= meta;
      hist <= sync;
    end
  end

  assign q    = sync;
  assign rise = sync & ~hist;
  assign fall = ~sync & hist;

endmodule

// File: rtl/spi_slave.sv
// SPI slave, all four modes, LSB first, oversampling sclk/cs_n/mosi in the clk
// domain. One-entry transmit buffer feeds the shift register at each frame start.
module spi_slave
  import spi_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic             mosi,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             underrun,
  output logic             abort,
  output logic             miso,
  output logic             miso_oe
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic cs_q, cs_rise, cs_fall;
  logic sclk_q, sclk_rise, sclk_fall;
  logic mosi_q, mosi_rise, mosi_fall;
  logic [3:0] sync_unused;

  spi_sync #(.RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .d(cs_n), .q(cs_q), .rise(cs_rise), .fall(cs_fall)
  );
  spi_sync #(.RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .d(sclk), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync #(.RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .d(mosi), .q(mosi_q), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign sync_unused = {cs_q, sclk_q, mosi_rise, mosi_fall};

  logic             state;
  logic [1:0]       mode_q;
  logic [CW-1:0]    bit_cnt;
  logic [WIDTH-1:0] rx_shift;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] buf_data;
  logic             buf_full;
  logic             skip_shift;

  logic activate, deactivate;
  logic leading, trailing, sample_edge, shift_edge;
  logic frame_done, reload, buf_load;

  // NOTE: every signal gets a default at the top of always_comb so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    leading     = 1'b0;
    trailing    = 1'b0;
    sample_edge = 1'b0;
    shift_edge  = 1'b0;
    if (state == STATE_ACTIVE && !cs_rise) begin
      leading     = mode_cpol(mode_q) ? sclk_fall : sclk_rise;
      trailing    = mode_cpol(mode_q) ? sclk_rise : sclk_fall;
      sample_edge = mode_cpha(mode_q) ? trailing : leading;
      shift_edge  = mode_cpha(mode_q) ? leading  : trailing;
    end
  end

  assign activate   = (state == STATE_IDLE) && cs_fall;
  assign deactivate = (state == STATE_ACTIVE) && cs_rise;
  assign frame_done = sample_edge && (bit_cnt == LAST_BIT);
  assign reload     = activate || frame_done;
  assign buf_load   = tx_valid && !buf_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= STATE_IDLE;
      mode_q   <= MODE_CPOL0_CPHA0;
      bit_cnt  <= '0;
      rx_shift <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      abort    <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      abort    <= 1'b0;
      if (activate) begin
        state   <= STATE_ACTIVE;
        mode_q  <= mode;
        bit_cnt <= '0;
      end else if (deactivate) begin
        // A partial frame is dropped; only the abort pulse reports it.
        state   <= STATE_IDLE;
        bit_cnt <= '0;
        abort   <= (bit_cnt != '0);
      end else if (sample_edge) begin
        rx_shift <= {mosi_q, rx_shift[WIDTH-1:1]};
        bit_cnt  <= frame_done ? '0 : bit_cnt + CW'(1);
        if (frame_done) begin
          rx_data  <= {mosi_q, rx_shift[WIDTH-1:1]};
          rx_valid <= 1'b1;
        end
      end
    end
  end

  // After a reload the next shift edge is swallowed: for phase 1 that is the
  // first leading edge, for phase 0 the trailing edge of the frame's last bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_shift   <= '0;
      buf_data   <= '0;
      buf_full   <= 1'b0;
      skip_shift <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      underrun <= 1'b0;
      if (reload) begin
        tx_shift   <= buf_full ? buf_data : '0;
        buf_full   <= 1'b0;
        underrun   <= !buf_full;
        skip_shift <= activate ? mode_cpha(mode) : 1'b1;
      end else if (shift_edge) begin
        if (skip_shift) skip_shift <= 1'b0;
        else            tx_shift   <= tx_shift >> 1;
      end
      // Placed after the reload so an entry accepted this cycle survives it.
      if (buf_load) begin
        buf_data <= tx_data;
        buf_full <= 1'b1;
      end
    end
  end

  assign tx_ready = !buf_full;
  assign miso_oe  = (state == STATE_ACTIVE);
  assign miso     = (state == STATE_ACTIVE) && tx_shift[0];

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a bit-banged SPI master drives frames in
// all modes while a monitor pops expected receive bytes from a scoreboard queue.
module tb_spi_slave;

  localparam int WIDTH = 8;
  localparam int HALF  = 8;  // clk cycles per sclk half period

  logic             clk = 1'b0;
  logic             reset;
  logic             sclk, cs_n, mosi;
  logic [1:0]       mode;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid, underrun, abort, miso, miso_oe;

  always #5 clk = ~clk;

  spi_slave #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .mode(mode),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .underrun(underrun), .abort(abort),
    .miso(miso), .miso_oe(miso_oe)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] rx_exp[$];
  logic [WIDTH-1:0] exp_byte;
  int   rx_cnt = 0, abort_cnt = 0, underrun_cnt = 0, wide_cnt = 0;
  logic rx_valid_prev = 1'b0;

  // Scoreboard monitor: each rx_valid pops one expected byte.
  always @(negedge clk) begin
    if (rx_valid) begin
      rx_cnt++;
      n_checks++;
      if (rx_exp.size() == 0) begin
        n_fail++;
        $display("FAIL rx_unexpected: got rx_data %h, required no rx_valid", rx_data);
      end else begin
        exp_byte = rx_exp.pop_front();
        if (rx_data !== exp_byte) begin
          n_fail++;
          $display("FAIL rx_data: got %h, required %h", rx_data, exp_byte);
        end
      end
      if (rx_valid_prev) wide_cnt++;
    end
    rx_valid_prev = rx_valid;
    if (abort)    abort_cnt++;
    if (underrun) underrun_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load_tx(input logic [WIDTH-1:0] d);
    int t = 0;
    while (!tx_ready && t < 100) begin
      cycles(1);
      t++;
    end
    n_checks++;
    if (tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL tx_ready_wait: got %b, required 1", tx_ready);
    end
    tx_data  = d;
    tx_valid = 1'b1;
    cycles(1);
    tx_valid = 1'b0;
    n_checks++;
    if (tx_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_ready_after_load: got %b, required 0", tx_ready);
    end
  endtask

  task automatic select(input logic [1:0] m);
    mode = m;
    sclk = m[1];
    cycles(4);
    cs_n = 1'b0;
    cycles(6);
  endtask

  task automatic deselect();
    cycles(6);
    cs_n = 1'b1;
    cycles(6);
  endtask

  // Bit-banged master; a full frame pushes its mosi byte as the expected rx.
  task automatic xfer(input logic [1:0] m, input logic [WIDTH-1:0] out,
                      input int nbits, output logic [WIDTH-1:0] in);
    logic cpol, cpha;
    cpol = m[1];
    cpha = m[1] ^ m[0];
    in   = '0;
    if (nbits == WIDTH) rx_exp.push_back(out);
    for (int i = 0; i < nbits; i++) begin
      if (!cpha) begin
        mosi = out[i];
        cycles(HALF);
        in[i] = miso;
        sclk  = ~cpol;
        cycles(HALF);
        sclk  = cpol;
      end else begin
        sclk = ~cpol;
        mosi = out[i];
        cycles(HALF);
        in[i] = miso;
        sclk  = cpol;
        cycles(HALF);
      end
    end
  endtask

  task automatic test_reset();
    logic [WIDTH-1:0] got[7];
    logic [WIDTH-1:0] req[7];
    string            nm[7];
    reset = 1'b0;
    cycles(3);
    got = '{rx_data, 8'(rx_valid), 8'(underrun), 8'(abort), 8'(miso), 8'(miso_oe), 8'(tx_ready)};
    req = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    nm  = '{"rst_rx_data", "rst_rx_valid", "rst_underrun", "rst_abort", "rst_miso", "rst_miso_oe", "rst_tx_ready"};
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (got[i] !== req[i]) begin
        n_fail++;
        $display("FAIL %s: got %h, required %h", nm[i], got[i], req[i]);
      end
    end
    reset = 1'b1;
    cycles(4);
    n_checks++;
    if (miso_oe !== 1'b0 || tx_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL post_reset_idle: got oe=%b ready=%b, required oe=0 ready=1", miso_oe, tx_ready);
    end
  endtask

  task automatic test_mode00();
    logic [WIDTH-1:0] got;
    int r0;
    r0 = rx_cnt;
    load_tx(8'hA5);
    select(2'b00);
    n_checks++;
    if (miso_oe !== 1'b1) begin
      n_fail++;
      $display("FAIL m00_miso_oe_active: got %b, required 1", miso_oe);
    end
    xfer(2'b00, 8'h3C, WIDTH, got);
    deselect();
    n_checks++;
    if (got !== 8'hA5) begin
      n_fail++;
      $display("FAIL m00_miso_byte: got %h, required a5", got);
    end
    n_checks++;
    if (rx_cnt - r0 !== 1 || wide_cnt !== 0) begin
      n_fail++;
      $display("FAIL m00_rx_pulses: got %0d pulses (%0d wide), required 1 (0 wide)", rx_cnt - r0, wide_cnt);
    end
    n_checks++;
    if (miso_oe !== 1'b0 || rx_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL m00_after_deselect: got oe=%b rx_data=%h, required oe=0 rx_data=3c", miso_oe, rx_data);
    end
  endtask

  task automatic test_other_modes();
    logic [WIDTH-1:0] got;
    logic [1:0] modes[3] = '{2'b01, 2'b10, 2'b11};
    for (int k = 0; k < 3; k++) begin
      load_tx(8'hF0);
      select(modes[k]);
      xfer(modes[k], 8'hF0, WIDTH, got);
      deselect();
      n_checks++;
      if (got !== 8'hF0) begin
        n_fail++;
        $display("FAIL mode%b_miso_bits: got %b (lsb first), required 11110000", modes[k], got);
      end
      n_checks++;
      if (rx_exp.size() != 0) begin
        n_fail++;
        $display("FAIL mode%b_rx_missing: got %0d pending, required 0", modes[k], rx_exp.size());
        rx_exp.delete();
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] got0, got1;
    int r0;
    r0 = rx_cnt;
    load_tx(8'h11);
    select(2'b00);
    load_tx(8'h22);
    xfer(2'b00, 8'h11, WIDTH, got0);
    xfer(2'b00, 8'h22, WIDTH, got1);
    deselect();
    n_checks++;
    if (got0 !== 8'h11 || got1 !== 8'h22) begin
      n_fail++;
      $display("FAIL b2b_miso: got %h %h, required 11 22", got0, got1);
    end
    n_checks++;
    if (rx_cnt - r0 !== 2 || rx_exp.size() != 0 || wide_cnt !== 0) begin
      n_fail++;
      $display("FAIL b2b_rx_pulses: got %0d pulses, required 2", rx_cnt - r0);
      rx_exp.delete();
    end
  endtask

  task automatic test_abort();
    logic [WIDTH-1:0] got;
    int r0, a0;
    r0 = rx_cnt;
    a0 = abort_cnt;
    load_tx(8'h5A);
    select(2'b00);
    xfer(2'b00, 8'h1F, 5, got);
    deselect();
    n_checks++;
    if (abort_cnt - a0 !== 1) begin
      n_fail++;
      $display("FAIL abort_pulse: got %0d pulses, required 1", abort_cnt - a0);
    end
    n_checks++;
    if (rx_cnt !== r0) begin
      n_fail++;
      $display("FAIL abort_no_rx_valid: got %0d pulses, required 0", rx_cnt - r0);
    end
    load_tx(8'h81);
    select(2'b00);
    xfer(2'b00, 8'h81, WIDTH, got);
    deselect();
    n_checks++;
    if (got !== 8'h81 || rx_cnt - r0 !== 1 || rx_exp.size() != 0) begin
      n_fail++;
      $display("FAIL abort_recovery: got miso %h, %0d pulses, required 81, 1", got, rx_cnt - r0);
      rx_exp.delete();
    end
  endtask

  task automatic test_underrun();
    logic [WIDTH-1:0] got;
    int u0;
    u0 = underrun_cnt;
    select(2'b00);
    n_checks++;
    if (underrun_cnt - u0 !== 1) begin
      n_fail++;
      $display("FAIL underrun_pulse: got %0d pulses, required 1", underrun_cnt - u0);
    end
    xfer(2'b00, 8'h77, WIDTH, got);
    deselect();
    n_checks++;
    if (got !== 8'h00) begin
      n_fail++;
      $display("FAIL underrun_miso: got %h, required 00", got);
    end
    n_checks++;
    if (rx_exp.size() != 0) begin
      n_fail++;
      $display("FAIL underrun_rx_missing: got %0d pending, required 0", rx_exp.size());
      rx_exp.delete();
    end
  endtask

  task automatic test_reset_midframe();
    logic [WIDTH-1:0] got;
    logic [WIDTH-1:0] obs[7];
    logic [WIDTH-1:0] req[7];
    string            nm[7];
    int a0, r0;
    load_tx(8'hC3);
    select(2'b00);
    xfer(2'b00, 8'hFF, 3, got);
    a0 = abort_cnt;
    r0 = rx_cnt;
    reset = 1'b0;
    cycles(2);
    obs = '{rx_data, 8'(rx_valid), 8'(underrun), 8'(abort), 8'(miso), 8'(miso_oe), 8'(tx_ready)};
    req = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
    nm  = '{"mid_rx_data", "mid_rx_valid", "mid_underrun", "mid_abort", "mid_miso", "mid_miso_oe", "mid_tx_ready"};
    for (int i = 0; i < 7; i++) begin
      n_checks++;
      if (obs[i] !== req[i]) begin
        n_fail++;
        $display("FAIL %s: got %h, required %h", nm[i], obs[i], req[i]);
      end
    end
    cs_n = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    cycles(3);
    reset = 1'b1;
    cycles(8);
    n_checks++;
    if (abort_cnt !== a0 || rx_cnt !== r0) begin
      n_fail++;
      $display("FAIL mid_silent: got %0d abort %0d rx pulses, required 0 0", abort_cnt - a0, rx_cnt - r0);
    end
    load_tx(8'h3C);
    select(2'b00);
    xfer(2'b00, 8'h5A, WIDTH, got);
    deselect();
    n_checks++;
    if (got !== 8'h3C || rx_exp.size() != 0) begin
      n_fail++;
      $display("FAIL mid_resume: got miso %h, %0d rx pending, required 3c, 0", got, rx_exp.size());
      rx_exp.delete();
    end
  endtask

  initial begin
    reset    = 1'b0;
    sclk     = 1'b0;
    cs_n     = 1'b1;
    mosi     = 1'b0;
    mode     = 2'b00;
    tx_data  = '0;
    tx_valid = 1'b0;
    test_reset();
    test_mode00();
    test_other_modes();
    test_back_to_back();
    test_abort();
    test_underrun();
    test_reset_midframe();
    cycles(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
